// File: rtl/reg_wb_arbiter.sv
// Write-back controller: round-robin arbitration of NUM_REQ requesters onto the single
// register-file write port, plus a pending-write scoreboard (optional forwarding: REG_WB_FWD_EN).
module reg_wb_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      pend_set,
    input  logic [ADDR_W-1:0]         pend_addr,
    input  logic [ADDR_W-1:0]         rd_addr1,
    input  logic [ADDR_W-1:0]         rd_addr2,
    output logic                      hazard1,
    output logic                      hazard2,
    output logic [ADDR_W-1:0]         write_addr,
    output logic [DATA_W-1:0]         write_value,
    output logic                      write_enable,
    output logic [2**ADDR_W-1:0]      pending
`ifdef REG_WB_FWD_EN
    ,
    output logic                      fwd1_valid,
    output logic                      fwd2_valid,
    output logic [DATA_W-1:0]         fwd_value
`endif
);

    localparam int NREG  = 2**ADDR_W;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [PTR_W-1:0]  r_ptr;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wval;
    logic              r_we;
    logic [NREG-1:0]   r_pend;

    logic [NUM_REQ-1:0] w_grant;
    logic               w_found;
    int                 w_win;
    int                 w_idx;
    int                 w_next;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic [NREG-1:0]    w_set;
    logic [NREG-1:0]    w_clr;

    // First valid requester at or after the pointer, wrapping; r_ptr < NUM_REQ keeps one subtract enough.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        w_found = 1'b0;
        w_win   = 0;
        w_idx   = 0;
        w_grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        w_grant[w_win] = w_found;
        w_next         = (w_win == NUM_REQ - 1) ? 0 : w_win + 1;
    end

    assign w_sel_addr = req_addr[w_win*ADDR_W +: ADDR_W];
    assign w_sel_data = req_data[w_win*DATA_W +: DATA_W];
    assign req_ready  = rst_n ? w_grant : '0;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (pend_set && pend_addr != ZERO_A) w_set[pend_addr] = 1'b1;
        if (r_we) w_clr[r_waddr] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wval  <= '0;
            r_pend  <= '0;
        end else begin
            r_we <= w_found && (w_sel_addr != ZERO_A);
            if (w_found) begin
                r_ptr   <= PTR_W'(w_next);
                r_waddr <= w_sel_addr;
                r_wval  <= w_sel_data;
            end
            // Set is applied after clear so a re-issued writer stays outstanding.
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    assign write_enable = r_we;
    assign write_addr   = r_waddr;
    assign write_value  = r_wval;
    assign pending      = r_pend;

`ifdef REG_WB_FWD_EN
    assign fwd1_valid = r_we && (r_waddr == rd_addr1);
    assign fwd2_valid = r_we && (r_waddr == rd_addr2);
    assign fwd_value  = r_wval;
    assign hazard1    = r_pend[rd_addr1] && (rd_addr1 != ZERO_A) && !fwd1_valid;
    assign hazard2    = r_pend[rd_addr2] && (rd_addr2 != ZERO_A) && !fwd2_valid;
`else
    assign hazard1    = r_pend[rd_addr1] && (rd_addr1 != ZERO_A);
    assign hazard2    = r_pend[rd_addr2] && (rd_addr2 != ZERO_A);
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Randomized + directed bench for reg_wb_arbiter against a behavioural model
// (register array, pending flags, round-robin index, one-deep write pipeline).
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_addr;
    logic [63:0] req_data;
    logic        pend_set;
    logic [2:0]  pend_addr;
    logic [2:0]  rd_addr1;
    logic [2:0]  rd_addr2;
    logic        hazard1;
    logic        hazard2;
    logic [2:0]  write_addr;
    logic [31:0] write_value;
    logic        write_enable;
    logic [7:0]  pending;
`ifdef REG_WB_FWD_EN
    logic        fwd1_valid;
    logic        fwd2_valid;
    logic [31:0] fwd_value;
`endif

    reg_wb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .pend_set     (pend_set),
        .pend_addr    (pend_addr),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .hazard1      (hazard1),
        .hazard2      (hazard2),
        .write_addr   (write_addr),
        .write_value  (write_value),
        .write_enable (write_enable),
        .pending      (pending)
`ifdef REG_WB_FWD_EN
        ,
        .fwd1_valid   (fwd1_valid),
        .fwd2_valid   (fwd2_valid),
        .fwd_value    (fwd_value)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_pend[8];
    int          m_ptr;
    bit          m_we;
    int          m_waddr;
    logic [31:0] m_wval;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 8; j++) m_pend[j] = 1'b0;
        m_ptr = 0;
        m_we  = 1'b0;
        m_waddr = 0;
        m_wval  = '0;
    endtask

    task automatic drive_idle();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        pend_set  = 1'b0;
        pend_addr = '0;
        rd_addr1  = '0;
        rd_addr2  = '0;
    endtask

    // One clock cycle: drive, check everything visible this cycle, then advance the model.
    task automatic step(input logic [1:0] v, input logic [2:0] a0, input logic [2:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic ps, input logic [2:0] pa,
                        input logic [2:0] r1, input logic [2:0] r2);
        bit         found;
        int         win;
        int         tgt;
        logic [7:0] exp_pend;
        bit         h1, h2, f1, f2;
        bit         nxt[8];
        @(negedge clk);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        pend_set  = ps;
        pend_addr = pa;
        rd_addr1  = r1;
        rd_addr2  = r2;
        #1;
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < 2; k++) begin
            int i;
            i = (m_ptr + k) % 2;
            if (!found && v[i]) begin
                found = 1'b1;
                win   = i;
            end
        end
        for (int j = 0; j < 8; j++) exp_pend[j] = m_pend[j];
        f1 = m_we && (m_waddr == int'(r1));
        f2 = m_we && (m_waddr == int'(r2));
        h1 = m_pend[r1] && (r1 != 3'd7);
        h2 = m_pend[r2] && (r2 != 3'd7);
`ifdef REG_WB_FWD_EN
        h1 = h1 && !f1;
        h2 = h2 && !f2;
        check("fwd1_valid", 64'(fwd1_valid), 64'(f1));
        check("fwd2_valid", 64'(fwd2_valid), 64'(f2));
        if (m_we) check("fwd_value", 64'(fwd_value), 64'(m_wval));
`endif
        check("req_ready", 64'(req_ready), found ? 64'(2'b01 << win) : 64'(0));
        check("hazard1", 64'(hazard1), 64'(h1));
        check("hazard2", 64'(hazard2), 64'(h2));
        check("write_enable", 64'(write_enable), 64'(m_we));
        check("pending", 64'(pending), 64'(exp_pend));
        if (m_we) begin
            check("write_addr", 64'(write_addr), 64'(m_waddr));
            check("write_value", 64'(write_value), 64'(m_wval));
        end
        @(posedge clk);
        for (int j = 0; j < 8; j++)
            nxt[j] = (m_pend[j] && !(m_we && m_waddr == j)) || (ps && int'(pa) == j && j != 7);
        for (int j = 0; j < 8; j++) m_pend[j] = nxt[j];
        if (found) begin
            tgt     = (win == 1) ? int'(a1) : int'(a0);
            m_we    = (tgt != 7);
            m_waddr = tgt;
            m_wval  = (win == 1) ? d1 : d0;
            m_ptr   = (win + 1) % 2;
        end else begin
            m_we = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        model_reset();

        // Held in reset: everything quiet, no grants even with requests present.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = 2'($urandom_range(1, 3));
            #1;
            check("rst_ready", 64'(req_ready), 64'(0));
            check("rst_we", 64'(write_enable), 64'(0));
            check("rst_pending", 64'(pending), 64'(0));
            check("rst_waddr", 64'(write_addr), 64'(0));
            check("rst_wvalue", 64'(write_value), 64'(0));
        end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        // Single write with hazard tracking on r3.
        step(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd3, 3'd3, 3'd0);
        step(2'b01, 3'd3, 3'd0, 32'hDEADBEEF, 32'h0, 1'b0, 3'd0, 3'd3, 3'd3);
        step(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 3'd3, 3'd3);
        step(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 3'd3, 3'd3);

        // Both requesters busy: grants alternate.
        for (int c = 0; c < 4; c++)
            step(2'b11, 3'd1, 3'd2, 32'h1000 + c, 32'h2000 + c, 1'b0, 3'd0, 3'd1, 3'd2);
        step(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 3'd1, 3'd2);

        // Zero register: accepted, never written, never pending.
        step(2'b10, 3'd0, 3'd7, 32'h0, 32'h1234, 1'b0, 3'd0, 3'd7, 3'd7);
        step(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd7, 3'd7, 3'd7);
        step(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 3'd7, 3'd7);

        // Set and clear of r5 in the same cycle: set wins.
        step(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd5, 3'd5, 3'd0);
        step(2'b01, 3'd5, 3'd0, 32'h55, 32'h0, 1'b0, 3'd0, 3'd5, 3'd0);
        step(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd5, 3'd5, 3'd0);
        step(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 3'd5, 3'd0);

        // Reset in the cycle after a grant: pending write dropped, pointer back to 0.
        step(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd4, 3'd4, 3'd0);
        step(2'b01, 3'd4, 3'd0, 32'hCAFE, 32'h0, 1'b0, 3'd0, 3'd4, 3'd0);
        @(negedge clk);
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_we", 64'(write_enable), 64'(0));
        check("midrst_pending", 64'(pending), 64'(0));
        check("midrst_ready", 64'(req_ready), 64'(0));
        model_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        step(2'b11, 3'd1, 3'd2, 32'hA, 32'hB, 1'b0, 3'd0, 3'd0, 3'd0);
        step(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 3'd1, 3'd2);

        // Randomized traffic.
        for (int c = 0; c < 400; c++)
            step(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 $urandom, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
